// File: rtl/cmd_defs.sv
// rtl/cmd_defs.sv - shared state encoding, command codes and address width for the UART command decoder
package cmd_defs;

    localparam int         ADDR_W     = 24;
    localparam logic [7:0] CMD_WR_DEF = 8'h55;
    localparam logic [7:0] CMD_RD_DEF = 8'haa;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRIG    = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// rtl/cmd_timeout_cnt.sv - clearable saturating inter-byte gap counter with expiry strobe
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_expire
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    // r_cnt is the number of cycles since the last clear; the clearing edge itself counts as one,
    // so expiry here lets the registered error land exactly TIMEOUT_CYC cycles after the strobe.
    logic [CNT_W-1:0] r_cnt;

    // Count up while not cleared, holding at the top value so long gaps never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (TIMEOUT_CYC != 0) && !i_clr && (r_cnt >= LIMIT);

endmodule

// File: rtl/cmd_decode_plus.sv
// rtl/cmd_decode_plus.sv - UART frame decoder feeding the SDRAM write FIFO and controller triggers
module cmd_decode_plus
    import cmd_defs::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         ADDR_BYTES    = 0,
    parameter logic [7:0] CMD_WR        = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD        = CMD_RD_DEF,
    parameter int         TIMEOUT_CYC   = 1000
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              uart_flag,
    input  logic [7:0]        uart_data,
    input  logic              wfifo_full,
    output logic              wr_trig,
    output logic              rd_trig,
    output logic              wfifo_wr_en,
    output logic [7:0]        wfifo_data,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              frame_err,
    output logic              wfifo_ovf
);

    localparam logic [7:0] LAST_ADDR = 8'((ADDR_BYTES > 0) ? ADDR_BYTES - 1 : 0);
    localparam logic [7:0] LAST_PAY  = 8'(PAYLOAD_BYTES - 1);

    state_t            r_state, w_state_nxt;
    logic              r_op_wr, w_op_wr_nxt;
    logic [7:0]        r_idx, w_idx_nxt;
    logic [ADDR_W-1:0] r_addr_sh, w_addr_sh_nxt;
    logic              w_wr_en_nxt, w_err_nxt, w_ovf_nxt;
    logic              r_wr_trig, r_rd_trig, r_wr_en, r_err, r_ovf;
    logic [7:0]        r_wdata;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic              w_tmo_clr, w_tmo_expire;

    // Gap timer only runs while a frame is open; TRIG behaves like IDLE for decoding.
    assign w_tmo_clr = uart_flag || (r_state == ST_IDLE) || (r_state == ST_TRIG);

    cmd_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk   (sclk),
        .i_rst_n (s_rst_n),
        .i_clr   (w_tmo_clr),
        .o_expire(w_tmo_expire)
    );

    // Frame parser: decides the next state and what the registered outputs show next cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_op_wr_nxt   = r_op_wr;
        w_idx_nxt     = r_idx;
        w_addr_sh_nxt = r_addr_sh;
        w_wr_en_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_ovf_nxt     = r_ovf;
        unique case (r_state)
            ST_IDLE, ST_TRIG: begin
                // A byte arriving during TRIG starts the next frame without being lost.
                w_state_nxt = ST_IDLE;
                if (uart_flag) begin
                    if (uart_data == CMD_WR) begin
                        w_op_wr_nxt   = 1'b1;
                        w_ovf_nxt     = 1'b0;
                        w_idx_nxt     = '0;
                        w_addr_sh_nxt = '0;
                        if (ADDR_BYTES > 0) w_state_nxt = ST_ADDR;
                        else                w_state_nxt = ST_PAYLOAD;
                    end else if (uart_data == CMD_RD) begin
                        w_op_wr_nxt   = 1'b0;
                        w_idx_nxt     = '0;
                        w_addr_sh_nxt = '0;
                        if (ADDR_BYTES > 0) w_state_nxt = ST_ADDR;
                        else                w_state_nxt = ST_TRIG;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_tmo_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (uart_flag) begin
                    w_addr_sh_nxt = {r_addr_sh[ADDR_W-9:0], uart_data};
                    if (r_idx == LAST_ADDR) begin
                        w_idx_nxt = '0;
                        if (r_op_wr) w_state_nxt = ST_PAYLOAD;
                        else         w_state_nxt = ST_TRIG;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_tmo_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (uart_flag) begin
                    // A byte refused by a full FIFO still counts toward the frame length.
                    if (!wfifo_full) w_wr_en_nxt = 1'b1;
                    else             w_ovf_nxt   = 1'b1;
                    if (r_idx == LAST_PAY) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_TRIG;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame context and registered outputs; trigger and last FIFO write share one edge.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_op_wr    <= 1'b0;
            r_idx      <= '0;
            r_addr_sh  <= '0;
            r_wr_trig  <= 1'b0;
            r_rd_trig  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wdata    <= '0;
            r_cmd_addr <= '0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_op_wr   <= w_op_wr_nxt;
            r_idx     <= w_idx_nxt;
            r_addr_sh <= w_addr_sh_nxt;
            r_wr_trig <= (w_state_nxt == ST_TRIG) && w_op_wr_nxt;
            r_rd_trig <= (w_state_nxt == ST_TRIG) && !w_op_wr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_err     <= w_err_nxt;
            r_ovf     <= w_ovf_nxt;
            if (w_wr_en_nxt) r_wdata <= uart_data;
            if (w_state_nxt == ST_TRIG) r_cmd_addr <= w_addr_sh_nxt;
        end
    end

    assign wr_trig     = r_wr_trig;
    assign rd_trig     = r_rd_trig;
    assign wfifo_wr_en = r_wr_en;
    assign wfifo_data  = r_wdata;
    assign cmd_addr    = r_cmd_addr;
    assign frame_err   = r_err;
    assign wfifo_ovf   = r_ovf;

endmodule

// File: tb/tb_cmd_decode_plus.sv
// tb/tb_cmd_decode_plus.sv - randomized and directed bench for cmd_decode_plus against a frame-level model
module tb_cmd_decode_plus;

    localparam int B_PAY = 3;
    localparam int B_ADR = 2;
    localparam int B_TMO = 40;

    logic       sclk, s_rst_n, uart_flag, wfifo_full;
    logic [7:0] uart_data;

    logic        a_wt, a_rt, a_we, a_er, a_ov;
    logic [7:0]  a_dat;
    logic [23:0] a_adr;
    logic        b_wt, b_rt, b_we, b_er, b_ov;
    logic [7:0]  b_dat;
    logic [23:0] b_adr;

    cmd_decode_plus dut_a (
        .sclk(sclk), .s_rst_n(s_rst_n), .uart_flag(uart_flag), .uart_data(uart_data),
        .wfifo_full(wfifo_full), .wr_trig(a_wt), .rd_trig(a_rt), .wfifo_wr_en(a_we),
        .wfifo_data(a_dat), .cmd_addr(a_adr), .frame_err(a_er), .wfifo_ovf(a_ov)
    );

    cmd_decode_plus #(
        .PAYLOAD_BYTES(B_PAY), .ADDR_BYTES(B_ADR), .TIMEOUT_CYC(B_TMO)
    ) dut_b (
        .sclk(sclk), .s_rst_n(s_rst_n), .uart_flag(uart_flag), .uart_data(uart_data),
        .wfifo_full(wfifo_full), .wr_trig(b_wt), .rd_trig(b_rt), .wfifo_wr_en(b_we),
        .wfifo_data(b_dat), .cmd_addr(b_adr), .frame_err(b_er), .wfifo_ovf(b_ov)
    );

    logic [36:0] got0, got1;
    assign got0 = {a_wt, a_rt, a_we, a_dat, a_adr, a_er, a_ov};
    assign got1 = {b_wt, b_rt, b_we, b_dat, b_adr, b_er, b_ov};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int mp_pay[2] = '{4, B_PAY};
    int mp_adr[2] = '{0, B_ADR};
    int mp_tmo[2] = '{1000, B_TMO};

    // frame-level model: bytes collected so far in the open frame and the length it needs
    int          m_len[2], m_need[2], m_last[2];
    bit          m_wr[2];
    logic [23:0] m_adr[2];
    bit          e_wt[2], e_rt[2], e_we[2], e_er[2], e_ov[2];
    logic [7:0]  e_dat[2];
    logic [23:0] e_adr[2];

    // observed-event records for the directed checks
    int          rec_we[2], rec_wt[2], rec_rt[2], rec_er[2];
    int          rec_wt_cyc[2], rec_rt_cyc[2], rec_er_cyc[2];
    logic [23:0] rec_rt_addr[2];
    logic [31:0] rec_dsh[2];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic clear_rec();
        for (int k = 0; k < 2; k++) begin
            rec_we[k] = 0; rec_wt[k] = 0; rec_rt[k] = 0; rec_er[k] = 0;
            rec_wt_cyc[k] = -1; rec_rt_cyc[k] = -1; rec_er_cyc[k] = -1;
            rec_rt_addr[k] = '0; rec_dsh[k] = '0;
        end
    endtask

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish within 80000 cycles");
        $fatal(1, "watchdog");
    end

    // model step on each edge, then compare every output of both instances just after it
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_len[k] = 0; m_need[k] = 0; m_last[k] = 0; m_wr[k] = 0; m_adr[k] = '0;
            e_dat[k] = '0; e_adr[k] = '0; e_ov[k] = 0;
        end
        clear_rec();
        forever begin
            @(posedge sclk);
            for (int k = 0; k < 2; k++) begin
                e_wt[k] = 0; e_rt[k] = 0; e_we[k] = 0; e_er[k] = 0;
                if (!s_rst_n) begin
                    m_len[k] = 0; m_adr[k] = '0; e_dat[k] = '0; e_adr[k] = '0; e_ov[k] = 0;
                end else if (uart_flag) begin
                    if (m_len[k] == 0) begin
                        if (uart_data == 8'h55) begin
                            m_wr[k] = 1; m_need[k] = 1 + mp_adr[k] + mp_pay[k];
                            m_len[k] = 1; m_adr[k] = '0; e_ov[k] = 0;
                        end else if (uart_data == 8'haa) begin
                            m_wr[k] = 0; m_need[k] = 1 + mp_adr[k];
                            m_len[k] = 1; m_adr[k] = '0;
                        end else begin
                            e_er[k] = 1;
                        end
                    end else begin
                        if (m_len[k] <= mp_adr[k]) m_adr[k] = {m_adr[k][15:0], uart_data};
                        else if (!wfifo_full) begin e_we[k] = 1; e_dat[k] = uart_data; end
                        else e_ov[k] = 1;
                        m_len[k]++;
                    end
                    if (m_len[k] > 0 && m_len[k] == m_need[k]) begin
                        if (m_wr[k]) e_wt[k] = 1; else e_rt[k] = 1;
                        e_adr[k] = m_adr[k];
                        m_len[k] = 0;
                    end
                    m_last[k] = cyc;
                end else if (m_len[k] > 0 && mp_tmo[k] > 0 && (cyc + 1 - m_last[k]) == mp_tmo[k]) begin
                    e_er[k] = 1;
                    m_len[k] = 0;
                end
            end
            cyc = cyc + 1;
            #1;
            for (int k = 0; k < 2; k++) begin
                logic [36:0] g, x;
                g = (k == 0) ? got0 : got1;
                x = {e_wt[k], e_rt[k], e_we[k], e_dat[k], e_adr[k], e_er[k], e_ov[k]};
                check($sformatf("cycle%0d_dut%0d", cyc, k), {27'd0, g}, {27'd0, x});
                if (g[34]) begin rec_we[k]++; rec_dsh[k] = {rec_dsh[k][23:0], g[33:26]}; end
                if (g[36]) begin rec_wt[k]++; rec_wt_cyc[k] = cyc; end
                if (g[35]) begin rec_rt[k]++; rec_rt_cyc[k] = cyc; rec_rt_addr[k] = g[25:2]; end
                if (g[1])  begin rec_er[k]++; rec_er_cyc[k] = cyc; end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic full, output int at);
        @(negedge sclk);
        uart_flag = 1'b1; uart_data = b; wfifo_full = full; at = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sclk);
            uart_flag = 1'b0; wfifo_full = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge sclk);
        uart_flag = 1'b0; wfifo_full = 1'b0; s_rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        clear_rec();
    endtask

    initial begin
        int s, s12, s23, s78, saa;
        logic [7:0] b;
        s_rst_n = 1'b0; uart_flag = 1'b0; uart_data = 8'h00; wfifo_full = 1'b0;
        repeat (3) @(negedge sclk);
        #1;
        check("reset_outputs_a", {27'd0, got0}, 64'd0);
        check("reset_outputs_b", {27'd0, got1}, 64'd0);
        s_rst_n = 1'b1;
        clear_rec();

        // 1: default write frame with wide byte spacing
        send(8'h55, 1'b0, s); idle(279);
        send(8'h12, 1'b0, s); idle(279);
        send(8'h34, 1'b0, s); idle(279);
        send(8'h56, 1'b0, s); idle(279);
        send(8'h78, 1'b0, s78); idle(5);
        check("t1_wr_en_count", rec_we[0], 4);
        check("t1_wdata_seq", rec_dsh[0], 32'h12345678);
        check("t1_wr_trig_cycle", rec_wt_cyc[0], s78 + 1);
        check("t1_wr_trig_count", rec_wt[0], 1);
        check("t1_frame_err", rec_er[0], 0);

        // 2: read frame with two address bytes
        do_reset();
        send(8'haa, 1'b0, s); idle(2);
        send(8'h01, 1'b0, s); idle(2);
        send(8'h23, 1'b0, s23); idle(3);
        check("t2_rd_trig_cycle", rec_rt_cyc[1], s23 + 1);
        check("t2_cmd_addr", rec_rt_addr[1], 24'h000123);
        check("t2_no_wr_en", rec_we[1], 0);

        // 3: FIFO full on one payload byte
        do_reset();
        send(8'h55, 1'b0, s); idle(2);
        send(8'h12, 1'b0, s); idle(2);
        send(8'h34, 1'b1, s); idle(2);
        send(8'h56, 1'b0, s); idle(2);
        send(8'h78, 1'b0, s); idle(2);
        check("t3_wdata_seq", rec_dsh[0], 32'h00125678);
        check("t3_wr_en_count", rec_we[0], 3);
        check("t3_ovf_set", a_ov, 1);
        check("t3_wr_trig_count", rec_wt[0], 1);
        send(8'h55, 1'b0, s); idle(2);
        check("t3_ovf_cleared", a_ov, 0);

        // 4: inter-byte timeout
        do_reset();
        send(8'h55, 1'b0, s); idle(3);
        send(8'h12, 1'b0, s12); idle(1010);
        check("t4_err_cycle", rec_er_cyc[0], s12 + 1000);
        check("t4_err_count", rec_er[0], 1);
        check("t4_no_wr_trig", rec_wt[0], 0);
        send(8'haa, 1'b0, s); idle(3);
        check("t4_rd_after", rec_rt[0], 1);

        // 5: unknown command byte
        do_reset();
        send(8'h3c, 1'b0, s); idle(3);
        check("t5_err_count", rec_er[0], 1);
        check("t5_err_cycle", rec_er_cyc[0], s + 1);
        send(8'haa, 1'b0, s); idle(3);
        check("t5_rd_after", rec_rt[0], 1);

        // 6: back-to-back frames, then reset mid-payload
        do_reset();
        send(8'h55, 1'b0, s); send(8'h12, 1'b0, s); send(8'h34, 1'b0, s);
        send(8'h56, 1'b0, s); send(8'h78, 1'b0, s78); send(8'haa, 1'b0, saa); idle(3);
        check("t6_wr_trig_cycle", rec_wt_cyc[0], s78 + 1);
        check("t6_rd_trig_cycle", rec_rt_cyc[0], s78 + 2);
        send(8'h55, 1'b0, s); send(8'h12, 1'b0, s); send(8'h34, 1'b0, s);
        @(negedge sclk);
        uart_flag = 1'b0; s_rst_n = 1'b0;
        #1;
        check("t6_reset_a", {27'd0, got0}, 64'd0);
        check("t6_reset_b", {27'd0, got1}, 64'd0);
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        clear_rec();
        idle(20);
        check("t6_quiet_after_reset", rec_wt[0] + rec_rt[0] + rec_we[0] + rec_er[0], 0);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            int r, gap;
            r = $urandom_range(0, 99);
            if (r < 40)      b = 8'h55;
            else if (r < 75) b = 8'haa;
            else             b = 8'($urandom_range(0, 255));
            send(b, ($urandom_range(0, 3) == 0), s);
            r = $urandom_range(0, 99);
            if (r < 70)      gap = $urandom_range(0, 3);
            else if (r < 97) gap = $urandom_range(4, 45);
            else             gap = $urandom_range(995, 1003);
            idle(gap);
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        idle(1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_decode_plus.md
Name: cmd_decode_plus

Overview:
Parametrised successor to the UART command decoder between the UART receiver and the SDRAM write FIFO and controller triggers. It parses the byte stream as frames of a command byte, an optional address field, and (for writes) a configurable-length payload.
- Payload bytes go to the write FIFO.
- Each completed frame produces a one-cycle write or read trigger with a latched address.
- Adds features the fixed 4-byte decoder lacks: an address field, FIFO-full overflow tracking, an inter-byte timeout, and error reporting.

Parameters:
PAYLOAD_BYTES, 4, write payload bytes per frame (1..256).
ADDR_BYTES, 0, address bytes after the command byte (0..3), MSB first.
CMD_WR, 8'h55, write command code.
CMD_RD, 8'haa, read command code.
TIMEOUT_CYC, 1000, idle sclk cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
sclk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
uart_flag  in  1  one-cycle strobe, uart_data valid
uart_data  in  8  received byte
wfifo_full  in  1  write FIFO full
wr_trig  out  1  one-cycle pulse: write frame complete
rd_trig  out  1  one-cycle pulse: read frame complete
wfifo_wr_en  out  1  FIFO write strobe
wfifo_data  out  8  FIFO write data
cmd_addr  out  24  frame address; bits above ADDR_BYTES*8 are 0
frame_err  out  1  one-cycle pulse: unknown command or timeout
wfifo_ovf  out  1  sticky: a payload byte was dropped because the FIFO was full

Behaviour:
- Clocking and reset: single clock sclk; reset is asynchronous and active-low on s_rst_n. Reset sets every output and internal counter to 0 and the state to IDLE.
- States: IDLE, ADDR, PAYLOAD, TRIG. All outputs are registered.
- IDLE, on uart_flag:
  - CMD_WR: op=WR, clear wfifo_ovf, go to ADDR (ADDR_BYTES>0) or PAYLOAD.
  - CMD_RD: op=RD, go to ADDR (ADDR_BYTES>0) or TRIG.
  - Any other byte: frame_err=1 next cycle, stay in IDLE.
- ADDR: each uart_flag shifts the byte into addr_sh (MSB first). After the ADDR_BYTES-th byte: go to PAYLOAD if WR, TRIG if RD.
- PAYLOAD, each uart_flag with the byte counter at k:
  - If wfifo_full=0: wfifo_wr_en=1 and wfifo_data=byte in the next cycle.
  - If wfifo_full=1: byte dropped, wfifo_ovf set, byte still counted.
  - After byte PAYLOAD_BYTES-1: go to TRIG.
- TRIG lasts exactly one cycle. It drives wr_trig or rd_trig high and loads cmd_addr from addr_sh (0 when ADDR_BYTES=0), then returns to IDLE.
- cmd_addr is stable from TRIG until the next TRIG.
- Latency, with the last byte strobed in cycle N:
  - WR: final wfifo_wr_en in N+1, wr_trig in N+1. The FIFO write and the trigger land in the same edge, so the FIFO sees the data before the controller samples.
  - RD: rd_trig in N+1.
  - Frame with no payload or address (RD, ADDR_BYTES=0): command strobe in N, rd_trig in N+1.
- A uart_flag during the TRIG cycle is decoded as an IDLE byte in that same cycle (back-to-back frames, no lost byte).
- Timeout:
  - The counter clears on every uart_flag and in IDLE, and increments otherwise.
  - In ADDR or PAYLOAD, reaching TIMEOUT_CYC gives frame_err=1 for one cycle and returns to IDLE with no trigger.
  - Bytes already written to the FIFO remain there; flushing is the controller's job.
- wr_trig, rd_trig and frame_err are never high together. wfifo_wr_en is only high in the cycle after a PAYLOAD byte.
- Reset mid-frame aborts with no pulses.

Decomposition:
- Shared defs file cmd_defs holds: the state encoding (IDLE=0, ADDR=1, PAYLOAD=2, TRIG=3), CMD_WR and CMD_RD defaults, and the ADDR_W=24 constant.
- One sub-module: cmd_timeout_cnt, a clearable saturating counter with parameter TIMEOUT_CYC and a one-cycle expiry output.

Test Plan:
1. Write frame, defaults: bytes 55,12,34,56,78, uart_flag 280 cycles apart, wfifo_full=0.
   -> 4 wfifo_wr_en pulses with data 12,34,56,78; wr_trig 1 cycle after the 78 strobe; frame_err=0.
2. Read frame, ADDR_BYTES=2: bytes AA,01,23.
   -> rd_trig 1 cycle after the 23 strobe; cmd_addr=24'h000123; no wfifo_wr_en.
3. Overflow: write frame 55,12,34,56,78 with wfifo_full=1 during the 34 strobe.
   -> wfifo_data 12,56,78 only; wfifo_ovf=1; wr_trig still fires.
   -> A following 55 clears wfifo_ovf.
4. Timeout, TIMEOUT_CYC=1000: bytes 55,12 then silence.
   -> frame_err pulse 1000 cycles after the 12 strobe; no wr_trig.
   -> Next byte AA produces a clean read (rd_trig).
5. Unknown command: byte 3C.
   -> frame_err for 1 cycle; state stays IDLE.
   -> Following AA gives rd_trig (ADDR_BYTES=0).
6. Back-to-back and reset:
   - AA strobed in the TRIG cycle of a write gives wr_trig then rd_trig on the next cycle.
   - s_rst_n low mid-payload clears all outputs; no trig after release.
